ps2_tx: RTL
===========

# ps2_tx

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xF4 "enable reporting" or 0xED "set LEDs") to a keyboard or mouse over the shared open-drain ps2c/ps2d lines. It follows the host request-to-send sequence, shifts out 8 data bits LSB first, then odd parity, then stop, and checks the device acknowledge. It sits beside the PS/2 receiver on the same pins. The top level uses tx_idle to gate the receiver so the host's own transmission is not decoded as an incoming scan code.

## Interface
- INHIBIT_CYCLES, default 8191: clk cycles ps2c is held low in request-to-send. 8191 cycles is about 164 us at 50 MHz; the minimum is 100 us.
- TIMEOUT_CYCLES, default 750000: maximum clk cycles to wait for any device falling edge (15 ms at 50 MHz).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- wr_ps2  in  1  single-cycle strobe; starts a transmission of din when tx_idle=1.
- din  in  8  command byte, sampled on the cycle wr_ps2 is accepted.
- ps2c  inout  1  PS/2 clock, open-drain: driven 0 or released (z), never driven 1.
- ps2d  inout  1  PS/2 data, open-drain: driven 0 or released (z), never driven 1.
- tx_idle  out  1  1 when in idle and no transfer is in progress.
- tx_done_tick  out  1  one-cycle pulse at the end of every transfer, whether it completed normally or aborted.
- tx_err  out  1  valid on the tx_done_tick cycle and held until the next accepted wr_ps2. 1 means the ack was missing or a timeout occurred.

## Operation
- Clock conditioning:
  - An 8-bit shift filter samples ps2c every clk.
  - Filtered clock f_ps2c sets to 1 when all 8 samples are 1, clears to 0 when all 8 are 0, and holds otherwise.
  - fall_edge = f_ps2c_reg & ~f_ps2c_next.
- Frame register b is 9 bits: {par, din}, with par = ~^din (odd parity). Bit counter n is 4 bits. Timer t is wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES).
- States:
  - idle: both lines released.
    - wr_ps2=1: load b, clear tx_err, set t=INHIBIT_CYCLES-1, go to rts.
  - rts: drive ps2c=0; ps2d released; fall_edge ignored; t decrements each cycle.
    - t==0: go to start, set t=TIMEOUT_CYCLES-1.
  - start: release ps2c; drive ps2d=0 (start bit).
    - fall_edge: n=8, go to data.
  - data: ps2d driven 0 when b[0]=0, released when b[0]=1.
    - fall_edge with n!=0: b shifts right by 1, n decrements.
    - fall_edge with n==0: go to stop.
    - Result: d0 is presented after edge 1, d1..d7 and parity after edges 2..9, and stop is entered on edge 10.
  - stop: ps2d released (stop bit = 1).
    - fall_edge (edge 11): sample ps2d. ps2d=0 means ack received; ps2d=1 sets tx_err. Then go to idle and pulse tx_done_tick.
- Watchdog: in start, data and stop, t reloads to TIMEOUT_CYCLES-1 on every fall_edge and decrements otherwise.
  - t==0: set tx_err, pulse tx_done_tick, release both lines, go to idle.
- wr_ps2 outside idle is ignored; din is not re-sampled.
- tx_idle=1 only in idle.
- Drive rules: output enables must come from registered or state-decoded signals, never from glitching combinational terms. When not driven, each line is z.

## Timing
- Reset values:
  - state=idle, filter=0, f_ps2c=0, b=0, n=0, t=0.
  - tx_idle=1, tx_done_tick=0, tx_err=0, both lines z.
- Reset mid-transfer releases both lines immediately, because reset is asynchronous.
- wr_ps2 accepted at cycle k:
  - tx_idle=0 at k+1.
  - ps2c low from k+1 through k+INHIBIT_CYCLES.
  - ps2d driven low from the first start cycle.
- ps2d changes one clk after the filtered falling edge. The filter delay is about 8 clk, which is well inside the device's low half-period of at least 30 us.
- tx_done_tick is asserted the cycle after the edge-11 fall_edge is detected; state is idle on that same cycle.
- The falling edge produced by rts's own ps2c drive must not advance the FSM.
- A fall_edge that coincides with t reaching 0 counts as an edge, not a timeout.

## Test plan
- Send 0xF4 (par=0). Device model clocks at 12.5 kHz and acks. Expected: bits seen at device rising edges are 0, 0,0,1,0,1,1,1,1, 0, 1; then tx_done_tick with tx_err=0; ps2c low for exactly INHIBIT_CYCLES clk.
- Send 0xED (par=1). Device model does not pull ps2d on edge 11. Expected: parity bit sampled as 1, tx_done_tick with tx_err=1, tx_idle=1 on the next cycle.
- Start 0x00, then the device stops clocking after edge 4. Expected: after TIMEOUT_CYCLES without a fall_edge, tx_done_tick with tx_err=1 and both lines z.
- Pulse wr_ps2 with din=0xAA while in the data state. Expected: ignored; the frame in flight completes unchanged.
- Assert reset in the data state. Expected: lines z and tx_idle=1 immediately. A following send of 0xF4 completes normally.
- Inject 1-5 clk glitches on ps2c during data. Expected: no extra shifts, and the frame still matches the 0xF4 bit sequence.

Source files
------------

// File: rtl/ps2_tx_if.sv
// Host-side command port of the PS/2 transmitter.
// wr_ps2 is a one-cycle strobe, accepted only while tx_idle=1; din is sampled on that
// cycle. tx_done_tick pulses once per transfer, and tx_err is valid from that pulse
// until the next accepted strobe.
interface ps2_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;

    modport master (output wr_ps2, din, input tx_idle, tx_done_tick, tx_err);
    modport slave  (input wr_ps2, din, output tx_idle, tx_done_tick, tx_err);
endinterface

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits LSB first, odd parity,
// stop, and device-ack check, on open-drain ps2c/ps2d lines.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 8191,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    ps2_tx_if.slave    bus,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic [2:0] o_dbg_state
);
    localparam int T_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW    = $clog2(T_MAX);
    localparam logic [TW-1:0] T_INH = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] T_TO  = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RTS   = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]    r_state, w_state_next;
    logic [7:0]    r_filter, w_filter_next;
    logic          r_f_ps2c, w_f_next, w_fall;
    logic [8:0]    r_b, w_b_next;
    logic [3:0]    r_n, w_n_next;
    logic [TW-1:0] r_t, w_t_next;
    logic          r_err, w_err_next;
    logic          r_done, w_done_next;
    logic          r_c_oe, r_d_oe;
    logic          w_t_zero;

    assign w_filter_next = {ps2c, r_filter[7:1]};
    assign w_f_next = (w_filter_next == 8'hFF) ? 1'b1 :
                      (w_filter_next == 8'h00) ? 1'b0 : r_f_ps2c;
    assign w_fall   = r_f_ps2c & ~w_f_next;
    assign w_t_zero = (r_t == '0);

    always_comb begin
        w_state_next = r_state;
        w_b_next     = r_b;
        w_n_next     = r_n;
        w_t_next     = r_t;
        w_err_next   = r_err;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.wr_ps2) begin
                    w_b_next     = {~^bus.din, bus.din};
                    w_err_next   = 1'b0;
                    w_t_next     = T_INH;
                    w_state_next = S_RTS;
                end
            end
            S_RTS: begin
                // Our own ps2c drive makes w_fall fire here; it is deliberately ignored.
                if (w_t_zero) begin
                    w_t_next     = T_TO;
                    w_state_next = S_START;
                end else begin
                    w_t_next = r_t - 1'b1;
                end
            end
            S_START, S_DATA, S_STOP: begin
                // An edge on the same cycle the watchdog expires still counts as an edge.
                if (w_fall) begin
                    w_t_next = T_TO;
                    if (r_state == S_START) begin
                        w_n_next     = 4'd8;
                        w_state_next = S_DATA;
                    end else if (r_state == S_DATA) begin
                        if (r_n == 4'd0) begin
                            w_state_next = S_STOP;
                        end else begin
                            w_b_next = {1'b0, r_b[8:1]};
                            w_n_next = r_n - 4'd1;
                        end
                    end else begin
                        w_err_next   = ps2d;
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end else if (w_t_zero) begin
                    w_err_next   = 1'b1;
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_t_next = r_t - 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_filter <= 8'h00;
            r_f_ps2c <= 1'b0;
            r_b      <= 9'h000;
            r_n      <= 4'd0;
            r_t      <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
            r_c_oe   <= 1'b0;
            r_d_oe   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_filter <= w_filter_next;
            r_f_ps2c <= w_f_next;
            r_b      <= w_b_next;
            r_n      <= w_n_next;
            r_t      <= w_t_next;
            r_err    <= w_err_next;
            r_done   <= w_done_next;
            // Enables are registered from next-state values: glitch-free, no extra latency.
            r_c_oe   <= (w_state_next == S_RTS);
            r_d_oe   <= (w_state_next == S_START) || ((w_state_next == S_DATA) && !w_b_next[0]);
        end
    end

    assign ps2c = r_c_oe ? 1'b0 : 1'bz;
    assign ps2d = r_d_oe ? 1'b0 : 1'bz;

    assign bus.tx_idle      = (r_state == S_IDLE);
    assign bus.tx_done_tick = r_done;
    assign bus.tx_err       = r_err;
    assign o_dbg_state      = r_state;
endmodule
